// File: rtl/mcu_sequencer.sv
// mcu_sequencer: multicycle control unit that fetches, decodes and sequences the integer datapath.
// Defining MCU_HILO_EN adds mult/div/mfhi/mflo; otherwise those functs trap to HALT.
module mcu_sequencer #(
  parameter logic [4:0] RESET_STATE = 5'd0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] ir,
  input  logic        im_ready,
  input  logic        dm_ready,
  input  logic        Z,
  input  logic        N,
  output logic        ir_ld,
  output logic        pc_ld,
  output logic [1:0]  pc_sel,
  output logic        im_cs,
  output logic        im_rd,
  output logic        dm_cs,
  output logic        dm_rd,
  output logic        dm_wr,
  output logic        imm_zext,
  output logic        D_En,
  output logic [1:0]  DA_Sel,
  output logic        S_Sel,
  output logic        T_Sel,
  output logic        D_In_Sel,
  output logic        HILO_ld,
  output logic [2:0]  Y_Sel,
  output logic [1:0]  D_OUT_Sel,
  output logic [4:0]  FS,
  output logic        halt,
  output logic [4:0]  state
);

  typedef enum logic [4:0] {
    RESET    = 5'd0,
    FETCH    = 5'd1,
    DECODE   = 5'd2,
    EXEC_R   = 5'd3,
    EXEC_I   = 5'd4,
    WB_RD    = 5'd5,
    WB_RT    = 5'd6,
    MEM_ADDR = 5'd7,
    LOAD_RD  = 5'd8,
    LOAD_WB  = 5'd9,
    STORE    = 5'd10,
    BRANCH   = 5'd11,
    JUMP     = 5'd12,
    JAL      = 5'd13,
    JR       = 5'd14,
    MULDIV   = 5'd15,
    MFHI     = 5'd16,
    MFLO     = 5'd17,
    HALT     = 5'd18
  } state_t;

  localparam logic [4:0] FS_PASS_S = 5'b00000;
  localparam logic [4:0] FS_ADD    = 5'b00010;
  localparam logic [4:0] FS_ADDU   = 5'b00011;
  localparam logic [4:0] FS_SUB    = 5'b00100;
  localparam logic [4:0] FS_SUBU   = 5'b00101;
  localparam logic [4:0] FS_SLT    = 5'b00110;
  localparam logic [4:0] FS_SLTU   = 5'b00111;
  localparam logic [4:0] FS_AND    = 5'b01000;
  localparam logic [4:0] FS_OR     = 5'b01001;
  localparam logic [4:0] FS_XOR    = 5'b01010;
  localparam logic [4:0] FS_NOR    = 5'b01011;
  localparam logic [4:0] FS_SLL    = 5'b01100;
  localparam logic [4:0] FS_SRL    = 5'b01101;
  localparam logic [4:0] FS_SRA    = 5'b01110;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  state_t     state_q, state_d;
  state_t     decode_next;
  logic [4:0] alu_fs;
  logic [5:0] opcode, funct;
  logic       is_ori, is_imm_alu, branch_taken;
  logic       unused_inputs;

  assign opcode        = ir[31:26];
  assign funct         = ir[5:0];
  assign is_ori        = (opcode == OP_ORI);
  assign is_imm_alu    = (opcode == OP_ADDI) || is_ori || (opcode == OP_LW);
  assign branch_taken  = (opcode == OP_BEQ) ? Z : ~Z;
  assign unused_inputs = ^{N, ir[25:6]};

  // Instruction decode: the state that follows DECODE and the ALU function it will use.
  always_comb begin
    decode_next = HALT;
    alu_fs      = FS_PASS_S;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          6'h20: begin decode_next = EXEC_R; alu_fs = FS_ADD;  end
          6'h21: begin decode_next = EXEC_R; alu_fs = FS_ADDU; end
          6'h22: begin decode_next = EXEC_R; alu_fs = FS_SUB;  end
          6'h23: begin decode_next = EXEC_R; alu_fs = FS_SUBU; end
          6'h24: begin decode_next = EXEC_R; alu_fs = FS_AND;  end
          6'h25: begin decode_next = EXEC_R; alu_fs = FS_OR;   end
          6'h26: begin decode_next = EXEC_R; alu_fs = FS_XOR;  end
          6'h27: begin decode_next = EXEC_R; alu_fs = FS_NOR;  end
          6'h2A: begin decode_next = EXEC_R; alu_fs = FS_SLT;  end
          6'h2B: begin decode_next = EXEC_R; alu_fs = FS_SLTU; end
          6'h00: begin decode_next = EXEC_R; alu_fs = FS_SLL;  end
          6'h02: begin decode_next = EXEC_R; alu_fs = FS_SRL;  end
          6'h03: begin decode_next = EXEC_R; alu_fs = FS_SRA;  end
          6'h08: decode_next = JR;
`ifdef MCU_HILO_EN
          6'h18: begin decode_next = MULDIV; alu_fs = 5'b11110; end
          6'h1A: begin decode_next = MULDIV; alu_fs = 5'b11111; end
          6'h10: decode_next = MFHI;
          6'h12: decode_next = MFLO;
`endif
          default: decode_next = HALT;
        endcase
      end
      OP_ADDI:       begin decode_next = EXEC_I;   alu_fs = FS_ADD; end
      OP_ORI:        begin decode_next = EXEC_I;   alu_fs = FS_OR;  end
      OP_LW, OP_SW:  begin decode_next = MEM_ADDR; alu_fs = FS_ADD; end
      OP_BEQ, OP_BNE: begin decode_next = BRANCH;  alu_fs = FS_SUB; end
      OP_J:          decode_next = JUMP;
      OP_JAL:        decode_next = JAL;
      default:       decode_next = HALT;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RESET:    state_d = FETCH;
      FETCH:    if (im_ready) state_d = DECODE;
      DECODE:   state_d = decode_next;
      EXEC_R:   state_d = WB_RD;
      EXEC_I:   state_d = WB_RT;
      MEM_ADDR: state_d = (opcode == OP_LW) ? LOAD_RD : STORE;
      LOAD_RD:  if (dm_ready) state_d = LOAD_WB;
      STORE:    if (dm_ready) state_d = FETCH;
      HALT:     state_d = HALT;
      default:  state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= state_t'(RESET_STATE);
    else       state_q <= state_d;
  end

  // Control word per state; pc_ld also follows im_ready in FETCH and the flag in BRANCH.
  always_comb begin
    ir_ld     = 1'b0;
    pc_ld     = 1'b0;
    pc_sel    = 2'b00;
    im_cs     = 1'b0;
    im_rd     = 1'b0;
    dm_cs     = 1'b0;
    dm_rd     = 1'b0;
    dm_wr     = 1'b0;
    imm_zext  = 1'b0;
    D_En      = 1'b0;
    DA_Sel    = 2'b00;
    S_Sel     = 1'b0;
    T_Sel     = 1'b0;
    D_In_Sel  = 1'b0;
    Y_Sel     = 3'b000;
    D_OUT_Sel = 2'b00;
    FS        = FS_PASS_S;
    case (state_q)
      FETCH:    begin im_cs = 1'b1; im_rd = 1'b1; ir_ld = 1'b1; pc_ld = im_ready; end
      DECODE:   begin T_Sel = is_imm_alu; imm_zext = is_ori; end
      EXEC_R:   FS = alu_fs;
      EXEC_I:   begin FS = alu_fs; T_Sel = 1'b1; imm_zext = is_ori; end
      WB_RD:    begin Y_Sel = 3'b010; D_En = 1'b1; end
      WB_RT:    begin Y_Sel = 3'b010; DA_Sel = 2'b01; D_En = 1'b1; end
      MEM_ADDR: begin FS = alu_fs; T_Sel = 1'b1; end
      LOAD_RD:  begin dm_cs = 1'b1; dm_rd = 1'b1; end
      LOAD_WB:  begin Y_Sel = 3'b011; DA_Sel = 2'b01; D_En = 1'b1; end
      STORE:    begin dm_cs = 1'b1; dm_wr = 1'b1; end
      BRANCH: begin
        FS     = alu_fs;
        pc_ld  = branch_taken;
        pc_sel = branch_taken ? 2'b01 : 2'b00;
      end
      JUMP:     begin pc_sel = 2'b10; pc_ld = 1'b1; end
      JAL: begin
        Y_Sel  = 3'b100;
        DA_Sel = 2'b10;
        D_En   = 1'b1;
        pc_sel = 2'b10;
        pc_ld  = 1'b1;
      end
      JR:       begin pc_sel = 2'b11; pc_ld = 1'b1; end
      MULDIV:   FS = alu_fs;
      MFHI:     begin Y_Sel = 3'b000; D_En = 1'b1; end
      MFLO:     begin Y_Sel = 3'b001; D_En = 1'b1; end
      default:  ;
    endcase
  end

`ifdef MCU_HILO_EN
  assign HILO_ld = (state_q == MULDIV);
`else
  assign HILO_ld = 1'b0;
`endif

  assign halt  = (state_q == HALT);
  assign state = state_q;

endmodule

// File: tb/tb_mcu_sequencer.sv
// tb_mcu_sequencer: randomized self-checking bench for mcu_sequencer.
// An instruction-level model predicts cycle counts, PC loads, write-backs and memory strobe totals.
`timescale 1ns/1ps
module tb_mcu_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] ir = 32'h0;
  logic        im_ready = 1'b0, dm_ready = 1'b0, Z = 1'b0, N = 1'b0;
  logic        ir_ld, pc_ld, im_cs, im_rd, dm_cs, dm_rd, dm_wr, imm_zext, D_En;
  logic        S_Sel, T_Sel, D_In_Sel, HILO_ld, halt;
  logic [1:0]  pc_sel, DA_Sel, D_OUT_Sel;
  logic [2:0]  Y_Sel;
  logic [4:0]  FS, state;

  int checks = 0;
  int failures = 0;

  localparam int ST_RESET = 0;
  localparam int ST_FETCH = 1;
  localparam int ST_HALT  = 18;

`ifdef MCU_HILO_EN
  localparam bit HILO = 1'b1;
`else
  localparam bit HILO = 1'b0;
`endif

  typedef struct {
    int         total;
    int         pcLds;
    logic [1:0] lastPcSel;
    int         dEns;
    int         dEnCycle;
    logic [1:0] daSel;
    logic [2:0] ySel;
    int         dmRds;
    int         dmWrs;
    int         hiloLds;
    int         jalOverlap;
    bit         fsValid;
    logic [4:0] fsExec;
    bit         illegal;
  } expect_t;

  mcu_sequencer dut (
    .clk(clk), .reset(reset), .ir(ir), .im_ready(im_ready), .dm_ready(dm_ready),
    .Z(Z), .N(N), .ir_ld(ir_ld), .pc_ld(pc_ld), .pc_sel(pc_sel), .im_cs(im_cs),
    .im_rd(im_rd), .dm_cs(dm_cs), .dm_rd(dm_rd), .dm_wr(dm_wr), .imm_zext(imm_zext),
    .D_En(D_En), .DA_Sel(DA_Sel), .S_Sel(S_Sel), .T_Sel(T_Sel), .D_In_Sel(D_In_Sel),
    .HILO_ld(HILO_ld), .Y_Sel(Y_Sel), .D_OUT_Sel(D_OUT_Sel), .FS(FS), .halt(halt),
    .state(state)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ALU function for an R-type ALU funct; bit 5 flags a recognised funct.
  function automatic logic [5:0] rTypeFs(input logic [5:0] fn);
    case (fn)
      6'h20: return {1'b1, 5'b00010};
      6'h21: return {1'b1, 5'b00011};
      6'h22: return {1'b1, 5'b00100};
      6'h23: return {1'b1, 5'b00101};
      6'h24: return {1'b1, 5'b01000};
      6'h25: return {1'b1, 5'b01001};
      6'h26: return {1'b1, 5'b01010};
      6'h27: return {1'b1, 5'b01011};
      6'h2A: return {1'b1, 5'b00110};
      6'h2B: return {1'b1, 5'b00111};
      6'h00: return {1'b1, 5'b01100};
      6'h02: return {1'b1, 5'b01101};
      6'h03: return {1'b1, 5'b01110};
      default: return 6'h00;
    endcase
  endfunction

  function automatic expect_t predict(input logic [31:0] instr, input int imW, input int dmW, input bit z);
    expect_t    e;
    logic [5:0] op, fn, rfs;
    op  = instr[31:26];
    fn  = instr[5:0];
    rfs = rTypeFs(fn);
    e = '{default: 0};
    e.pcLds = 1;
    e.total = imW + 3;
    e.dEnCycle = -1;
    e.fsValid = 1'b1;
    if (op == 6'h00 && rfs[5]) begin
      e.total = imW + 4; e.fsExec = rfs[4:0];
      e.dEns = 1; e.dEnCycle = imW + 3; e.daSel = 2'b00; e.ySel = 3'b010;
    end else if (op == 6'h00 && fn == 6'h08) begin
      e.pcLds = 2; e.lastPcSel = 2'b11;
    end else if (HILO && op == 6'h00 && (fn == 6'h18 || fn == 6'h1A)) begin
      e.hiloLds = 1; e.fsExec = (fn == 6'h18) ? 5'b11110 : 5'b11111;
    end else if (HILO && op == 6'h00 && (fn == 6'h10 || fn == 6'h12)) begin
      e.dEns = 1; e.dEnCycle = imW + 2; e.daSel = 2'b00;
      e.ySel = (fn == 6'h10) ? 3'b000 : 3'b001;
    end else if (op == 6'h08 || op == 6'h0D) begin
      e.total = imW + 4; e.fsExec = (op == 6'h08) ? 5'b00010 : 5'b01001;
      e.dEns = 1; e.dEnCycle = imW + 3; e.daSel = 2'b01; e.ySel = 3'b010;
    end else if (op == 6'h23) begin
      e.total = imW + 5 + dmW; e.fsExec = 5'b00010; e.dmRds = dmW + 1;
      e.dEns = 1; e.dEnCycle = imW + 4 + dmW; e.daSel = 2'b01; e.ySel = 3'b011;
    end else if (op == 6'h2B) begin
      e.total = imW + 4 + dmW; e.fsExec = 5'b00010; e.dmWrs = dmW + 1;
    end else if (op == 6'h04 || op == 6'h05) begin
      e.fsExec = 5'b00100;
      if ((op == 6'h04) == z) begin e.pcLds = 2; e.lastPcSel = 2'b01; end
    end else if (op == 6'h02) begin
      e.pcLds = 2; e.lastPcSel = 2'b10;
    end else if (op == 6'h03) begin
      e.pcLds = 2; e.lastPcSel = 2'b10; e.jalOverlap = 1;
      e.dEns = 1; e.dEnCycle = imW + 2; e.daSel = 2'b10; e.ySel = 3'b100;
    end else begin
      e.illegal = 1'b1; e.total = imW + 2; e.fsValid = 1'b0;
    end
    return e;
  endfunction

  function automatic logic [27:0] controlWord();
    return {ir_ld, pc_ld, pc_sel, im_cs, im_rd, dm_cs, dm_rd, dm_wr, imm_zext, D_En, DA_Sel,
            S_Sel, T_Sel, D_In_Sel, HILO_ld, Y_Sel, D_OUT_Sel, FS, halt};
  endfunction

  // Asserts reset asynchronously, then leaves the DUT in its first FETCH cycle.
  task automatic resetDut();
    reset = 1'b1; im_ready = 1'b0; dm_ready = 1'b0;
    #1;
    checkOutput("reset_state", 32'(state), ST_RESET);
    checkOutput("reset_controls", 32'(controlWord()), 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    checkOutput("reset_hold_state", 32'(state), ST_RESET);
    @(posedge clk); #1;
    checkOutput("reset_to_fetch", 32'(state), ST_FETCH);
  endtask

  task automatic applyStimulus(input logic [31:0] instr, input int imW, input int dmW, input bit z);
    expect_t    e;
    int         imCnt = 0, dmCnt = 0, pcLds = 0, dEns = 0, dEnCycle = -1, dmRds = 0, dmWrs = 0;
    int         hilos = 0, bothDm = 0, halts = 0, overlap = 0, strobes = 0;
    logic [1:0] lastSel = 2'b00, daSeen = 2'b00;
    logic [2:0] ySeen = 3'b000;
    logic [4:0] fsSeen = 5'b0;
    e = predict(instr, imW, dmW, z);
    ir = instr; Z = z; N = 1'($urandom);
    for (int c = 0; c < e.total; c++) begin
      im_ready = 1'b0; dm_ready = 1'b0;
      if (im_cs) begin im_ready = (imCnt == imW); imCnt++; end
      if (dm_cs) begin dm_ready = (dmCnt == dmW); dmCnt++; end
      #1;
      if (pc_ld) begin pcLds++; lastSel = pc_sel; end
      if (D_En) begin dEns++; dEnCycle = c; daSeen = DA_Sel; ySeen = Y_Sel; end
      if (D_En && pc_ld) overlap++;
      if (dm_rd) dmRds++;
      if (dm_wr) dmWrs++;
      if (dm_rd && dm_wr) bothDm++;
      if (HILO_ld) hilos++;
      if (halt) halts++;
      if (c == imW + 2) fsSeen = FS;
      @(posedge clk); #1;
    end
    im_ready = 1'b0; dm_ready = 1'b0;
    checkOutput($sformatf("end_state@%08h", instr), 32'(state), e.illegal ? ST_HALT : ST_FETCH);
    checkOutput($sformatf("pc_ld_count@%08h", instr), pcLds, e.pcLds);
    checkOutput($sformatf("pc_sel@%08h", instr), 32'(lastSel), 32'(e.lastPcSel));
    checkOutput($sformatf("d_en_count@%08h", instr), dEns, e.dEns);
    checkOutput($sformatf("dm_rd_cycles@%08h", instr), dmRds, e.dmRds);
    checkOutput($sformatf("dm_wr_cycles@%08h", instr), dmWrs, e.dmWrs);
    checkOutput($sformatf("dm_rd_wr_both@%08h", instr), bothDm, 0);
    checkOutput($sformatf("hilo_ld_count@%08h", instr), hilos, e.hiloLds);
    checkOutput($sformatf("halt_early@%08h", instr), halts, 0);
    checkOutput($sformatf("wb_with_pc_ld@%08h", instr), overlap, e.jalOverlap);
    if (e.dEns > 0) begin
      checkOutput($sformatf("d_en_cycle@%08h", instr), dEnCycle, e.dEnCycle);
      checkOutput($sformatf("da_sel@%08h", instr), 32'(daSeen), 32'(e.daSel));
      checkOutput($sformatf("y_sel@%08h", instr), 32'(ySeen), 32'(e.ySel));
    end
    if (e.fsValid) checkOutput($sformatf("fs@%08h", instr), 32'(fsSeen), 32'(e.fsExec));
    if (e.illegal) begin
      halts = 0;
      repeat (4) begin
        halts += int'(halt);
        strobes += int'(ir_ld | pc_ld | im_cs | im_rd | dm_cs | dm_rd | dm_wr | D_En | HILO_ld);
        @(posedge clk); #1;
      end
      checkOutput($sformatf("halt_sticky@%08h", instr), halts, 4);
      checkOutput($sformatf("halt_strobes@%08h", instr), strobes, 0);
      checkOutput($sformatf("halt_state@%08h", instr), 32'(state), ST_HALT);
      resetDut();
    end
  endtask

  // Walks a lw into its data-memory wait, then aborts it with reset.
  task automatic abortTest();
    ir = 32'h8C22_0004; im_ready = 1'b1; dm_ready = 1'b0;
    repeat (3) begin @(posedge clk); #1; im_ready = 1'b0; end
    checkOutput("abort_load_pending", 32'(dm_rd), 32'h1);
    resetDut();
    checkOutput("abort_no_dm_cs", 32'(dm_cs), 32'h0);
  endtask

  function automatic logic [31:0] randInstr(input bit allowIllegal);
    logic [5:0] fn;
    int         pick;
    logic [4:0] rs, rt, rd;
    logic [5:0] rFuncts [18] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A,
                                 6'h2B, 6'h00, 6'h02, 6'h03, 6'h08, 6'h18, 6'h1A, 6'h10, 6'h12};
    logic [5:0] iOps [9] = '{6'h08, 6'h0D, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h02, 6'h03, 6'h08};
    rs = 5'($urandom); rt = 5'($urandom); rd = 5'($urandom);
    pick = allowIllegal ? $urandom_range(0, 9) : $urandom_range(0, 8);
    if (pick < 4) begin
      fn = rFuncts[$urandom_range(0, 17)];
      return {6'h00, rs, rt, rd, 5'($urandom), fn};
    end else if (pick < 9) begin
      return {iOps[$urandom_range(0, 8)], rs, rt, 16'($urandom)};
    end else begin
      return ($urandom_range(0, 1) == 1) ? {6'h3F, 26'($urandom)} : {6'h00, rs, rt, rd, 5'd0, 6'h3F};
    end
  endfunction

  initial begin
    $display("[TB] mcu_sequencer bench start");
    #2;
    resetDut();
    applyStimulus(32'h0022_1820, 0, 0, 1'b0);
    applyStimulus(32'h8C23_0008, 0, 3, 1'b0);
    applyStimulus(32'hAC23_0008, 1, 2, 1'b0);
    applyStimulus(32'h1022_0004, 0, 0, 1'b1);
    applyStimulus(32'h1022_0004, 0, 0, 1'b0);
    applyStimulus(32'h1422_0004, 2, 0, 1'b0);
    applyStimulus(32'h0C00_0100, 0, 0, 1'b0);
    applyStimulus(32'h3422_00FF, 0, 0, 1'b0);
    applyStimulus(32'h0022_0018, 0, 0, 1'b0);
    applyStimulus(32'h0000_1812, 0, 0, 1'b0);
    applyStimulus(32'hFC00_0000, 0, 0, 1'b0);
    abortTest();
    for (int i = 0; i < 60; i++) begin
      applyStimulus(randInstr(1'b1), $urandom_range(0, 2), $urandom_range(0, 3), 1'($urandom));
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
